// File: rtl/four_bit_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, with a
// divide-by-zero bypass. Define FOUR_BIT_DIVIDER_SIGNED_EN for two's-complement operands.
module four_bit_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       start,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       busy,
    output logic       done,
    output logic       dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        accept_s;
    logic        busy_s;
    logic        done_s;

    logic [3:0]  a_r;
    logic [3:0]  dvd_r;
    logic [3:0]  dvs_r;
    logic [3:0]  rem_r;
    logic [3:0]  quo_r;
    logic [1:0]  cnt_r;
    logic        zero_r;

    logic [4:0]  shifted_s;
    logic [5:0]  diff_s;
    logic [3:0]  rem_next_s;
    logic        qbit_s;
    logic [3:0]  q_fin_s;
    logic [3:0]  r_fin_s;

`ifdef FOUR_BIT_DIVIDER_SIGNED_EN
    logic        neg_q_r;
    logic        neg_r_r;

    function automatic logic [3:0] mag4(input logic [3:0] v);
        if (v[3]) begin
            mag4 = 4'd0 - v;
        end else begin
            mag4 = v;
        end
    endfunction
`endif

    assign accept_s = (state_r == IDLE) && start;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (B == 4'd0) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == 2'd3) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode; busy/done are registered so they trail the state by one cycle
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        if (accept_s || (state_r != IDLE)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
        if (state_r == DONE) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // One restoring step; a kept difference is always below the divisor, so bit 4 is zero
    always_comb begin
        shifted_s  = {rem_r, dvd_r[3]};
        diff_s     = {1'b0, shifted_s} - {2'b00, dvs_r};
        rem_next_s = shifted_s[3:0];
        qbit_s     = 1'b0;
        if (diff_s[5:4] == 2'b00) begin
            rem_next_s = diff_s[3:0];
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = shifted_s[3:0];
            qbit_s     = 1'b0;
        end
    end

    // Final result, with sign restoration in the signed build
    always_comb begin
        q_fin_s = quo_r;
        r_fin_s = rem_r;
`ifdef FOUR_BIT_DIVIDER_SIGNED_EN
        if (neg_q_r) begin
            q_fin_s = 4'd0 - quo_r;
        end else begin
            q_fin_s = quo_r;
        end
        if (neg_r_r) begin
            r_fin_s = 4'd0 - rem_r;
        end else begin
            r_fin_s = rem_r;
        end
`endif
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= 4'd0;
            dvd_r  <= 4'd0;
            dvs_r  <= 4'd0;
            rem_r  <= 4'd0;
            quo_r  <= 4'd0;
            cnt_r  <= 2'd0;
            zero_r <= 1'b0;
            Q      <= 4'd0;
            R      <= 4'd0;
            dz     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef FOUR_BIT_DIVIDER_SIGNED_EN
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
`endif
        end else begin
            busy <= busy_s;
            done <= done_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r    <= A;
                        rem_r  <= 4'd0;
                        quo_r  <= 4'd0;
                        cnt_r  <= 2'd0;
                        zero_r <= (B == 4'd0);
`ifdef FOUR_BIT_DIVIDER_SIGNED_EN
                        dvd_r   <= mag4(A);
                        dvs_r   <= mag4(B);
                        neg_q_r <= A[3] ^ B[3];
                        neg_r_r <= A[3];
`else
                        dvd_r  <= A;
                        dvs_r  <= B;
`endif
                    end
                end
                CALC: begin
                    rem_r <= rem_next_s;
                    quo_r <= {quo_r[2:0], qbit_s};
                    dvd_r <= {dvd_r[2:0], 1'b0};
                    cnt_r <= cnt_r + 2'd1;
                end
                DONE: begin
                    if (zero_r) begin
                        Q  <= 4'hF;
                        R  <= a_r;
                        dz <= 1'b1;
                    end else begin
                        Q  <= q_fin_s;
                        R  <= r_fin_s;
                        dz <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_four_bit_divider.sv
// Randomized self-checking bench for four_bit_divider against an arithmetic
// reference model; define FOUR_BIT_DIVIDER_SIGNED_EN for the signed build.
module tb_four_bit_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Q;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic       dz;

    int n_checks = 0;
    int n_errors = 0;

    four_bit_divider dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .start (start),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_div(input logic [3:0] a, input logic [3:0] b,
                                    output logic [3:0] q, output logic [3:0] r,
                                    output logic z);
        int qi;
        int ri;
        if (b == 4'd0) begin
            q = 4'hF;
            r = a;
            z = 1'b1;
        end else begin
`ifdef FOUR_BIT_DIVIDER_SIGNED_EN
            qi = int'($signed(a)) / int'($signed(b));
            ri = int'($signed(a)) % int'($signed(b));
`else
            qi = int'(a) / int'(b);
            ri = int'(a) % int'(b);
`endif
            q = qi[3:0];
            r = ri[3:0];
            z = 1'b0;
        end
    endfunction

    // Called at a negedge; ends at a negedge with start low
    task automatic run_div(input logic [3:0] a, input logic [3:0] b, input int intrude_k);
        logic [3:0] eq, er, q_at, r_at;
        logic       edz, dz_at;
        int         done_k = -1;
        int         n_done = 0;
        int         n_busy = 0;
        logic       prev_done = 1'b0;
        logic       consec = 1'b0;
        ref_div(a, b, eq, er, edz);
        q_at = 4'd0;
        r_at = 4'd0;
        dz_at = 1'b0;
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_k < 0) begin
                    done_k = k;
                    q_at = Q;
                    r_at = R;
                    dz_at = dz;
                end
            end
            if (prev_done && done) consec = 1'b1;
            prev_done = done;
            if (busy) n_busy++;
            if (k == 0) begin
                A = 4'($urandom);
                B = 4'($urandom);
            end
            if (k == intrude_k) begin
                start = 1'b1;
                A = 4'd1;
                B = 4'd1;
            end else begin
                start = 1'b0;
            end
        end
        check("done_latency", done_k, (b == 4'd0) ? 1 : 5);
        check("done_count", n_done, 1);
        check("done_consecutive", consec, 1'b0);
        check("busy_cycles", n_busy, (b == 4'd0) ? 2 : 6);
        check("q", q_at, eq);
        check("r", r_at, er);
        check("dz", dz_at, edz);
        check("q_hold", Q, eq);
        check("r_hold", R, er);
    endtask

    initial begin
        logic [3:0] ra, rb, eq, er;
        logic       edz;
        int         n_done;
        logic       prev_done;
        logic       consec;

        rst = 1'b1;
        start = 1'b0;
        A = 4'd0;
        B = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {Q, R, busy, done, dz}, 11'd0);
        rst = 1'b0;

        // First edge after reset accepts start
        run_div(4'd13, 4'd4, -1);
        run_div(4'd15, 4'd1, -1);
        run_div(4'd2, 4'd7, -1);
        run_div(4'd7, 4'd0, -1);
        run_div(4'd9, 4'd2, 1);
`ifdef FOUR_BIT_DIVIDER_SIGNED_EN
        run_div(4'h9, 4'd2, -1);
        run_div(4'h8, 4'hF, -1);
        run_div(4'h8, 4'h1, -1);
`endif

        // Reset during the second CALC cycle
        A = 4'd11;
        B = 4'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_outputs", {Q, R, busy, done, dz}, 11'd0);
        rst = 1'b0;
        run_div(4'd14, 4'd3, -1);

        // Start held high relaunches on every IDLE visit
        A = 4'd10;
        B = 4'd3;
        start = 1'b1;
        ref_div(4'd10, 4'd3, eq, er, edz);
        n_done = 0;
        prev_done = 1'b0;
        consec = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                check("held_q", Q, eq);
                check("held_r", R, er);
            end
            if (prev_done && done) consec = 1'b1;
            prev_done = done;
        end
        start = 1'b0;
        check("held_done_count", n_done, 3);
        check("held_consecutive", consec, 1'b0);
        repeat (10) @(negedge clk);
        check("held_idle_busy", busy, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ra = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                rb = 4'd0;
            end else begin
                rb = 4'($urandom_range(1, 15));
            end
            run_div(ra, rb, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/four_bit_divider.md
FOUR_BIT_DIVIDER -- requirements
Module: four_bit_divider

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Port list SHALL be exactly as follows:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous active-high reset.
- `A`  input  4  dividend.
- `B`  input  4  divisor.
- `start`  input  1  request a division; sampled only in IDLE.
- `Q`  output  4  quotient.
- `R`  output  4  remainder.
- `busy`  output  1  high from the cycle after an accepted start until return to IDLE.
- `done`  output  1  one-cycle pulse; `Q`/`R`/`dz` valid.
- `dz`  output  1  divide-by-zero flag, valid with `done`.

Function
REQ-003 The block SHALL implement the inverse of the team's 4-bit add/sub path: sequential restoring division, one quotient bit per cycle, MSB first.
REQ-004 FSM states SHALL be IDLE, CALC and DONE.
REQ-005 FSM transitions SHALL be:
- IDLE→CALC on `start`=1 with `B`≠0.
- IDLE→DONE on `start`=1 with `B`=0.
- CALC→DONE after exactly 4 iterations.
- DONE→IDLE unconditionally.
REQ-006 On an accepted start, `A` and `B` SHALL be captured into internal registers; input changes after capture SHALL have no effect.
REQ-007 Each CALC iteration SHALL do the following:
- Shift the 5-bit partial remainder left, bringing in the next dividend bit.
- Subtract the divisor.
- If the result is ≥0, keep it and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
REQ-008 Latency for a nonzero divisor: start sampled at edge N → `busy`=1 from after edge N until IDLE is re-entered after edge N+6; `done`=1 only in the cycle after edge N+5.
REQ-009 Latency for a zero divisor: `done`=1 in the cycle after edge N+1, with `Q`=4'hF, `R`=captured `A` and `dz`=1.
REQ-010 `dz` SHALL be 0 for every nonzero divisor.
REQ-011 `Q`, `R` and `dz` SHALL hold their last result until the next accepted start; they MAY change during CALC.
REQ-012 `start` asserted while `busy`=1 SHALL be ignored, with no queuing.
REQ-013 `start` held high continuously SHALL launch a new division on each IDLE visit.
REQ-014 `done` SHALL never be high for two consecutive cycles.
REQ-015 Results SHALL satisfy A = Q*B + R with 0 ≤ R < B (unsigned build).

Reset
REQ-016 While `rst`=1 at a rising edge, the FSM SHALL go to IDLE and `Q`, `R`, `busy`, `done` and `dz` SHALL all be 0.
REQ-017 `rst` SHALL take priority over `start` and abort any in-progress division with no `done` pulse.
REQ-018 The first edge after reset deassertion SHALL be able to accept `start`.

Configuration
REQ-019 Macro `FOUR_BIT_DIVIDER_SIGNED_EN` SHALL select signed or unsigned operation.
- Defined: `A`, `B`, `Q` and `R` are two's complement. Magnitudes are divided unsigned; `Q` is negated when the operand signs differ, truncating toward zero. `R` takes the sign of `A`. The case -8/-1 yields `Q`=4'h8, `R`=0 (wraps). Divide-by-zero yields `Q`=4'hF, `R`=`A`, `dz`=1. Latency is unchanged.
- Undefined: all operands are unsigned per REQ-015, and no sign logic is synthesized.

Verification
REQ-020 A=13, B=4, start at edge N → `done` in the cycle after edge N+5, `Q`=3, `R`=1, `dz`=0.
REQ-021 A=15, B=1 → `Q`=15, `R`=0; then A=2, B=7 → `Q`=0, `R`=2.
REQ-022 A=7, B=0 → `done` in the cycle after edge N+1, `Q`=4'hF, `R`=7, `dz`=1; `busy` high exactly 2 cycles.
REQ-023 A=9, B=2 started; a second start with A=1, B=1 during CALC → ignored; single `done` with `Q`=4, `R`=1.
REQ-024 `rst` pulsed in the 2nd CALC cycle → no `done`, all outputs 0, IDLE; a start on the next edge completes correctly.
REQ-025 Signed build: A=-7 (4'h9), B=2 → `Q`=4'hD (-3), `R`=4'hF (-1); A=-8, B=-1 → `Q`=4'h8, `R`=0.
